// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ valid/ready lanes with dest and data.
// master drives valid/addr/data; slave (arbiter) drives one-hot ready.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [5*NUM_REQ-1:0]    req_addr;
  logic [XLEN*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port.
// Ports: clk, reset (async active-low), wb (request bus, slave),
//   reserve_valid/addr/ready (issue reservation), rs1/rs2_addr,
//   stall, busy[31:0] scoreboard, wr_en/wr_addr/wr_data to regfile.
// Optional: REGFILE_WB_BYPASS_EN releases stall in the grant cycle.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic            reserve_valid,
  input  logic [4:0]      reserve_addr,
  output logic            reserve_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            stall,
  output logic [31:0]     busy,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      nxt_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic [4:0]         g_addr;
  logic [XLEN-1:0]    g_data;
  int                 ptr;

  // Two passes: indices >= rr_ptr first, then the wrapped ones.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    nxt_ptr = rr_ptr;
    g_addr  = '0;
    g_data  = '0;
    ptr     = int'(rr_ptr);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && wb.req_valid[i] &&
            ((p == 0) == (i >= ptr))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          nxt_ptr = PW'((i + 1) % NUM_REQ);
          g_addr  = wb.req_addr[5*i +: 5];
          g_data  = wb.req_data[XLEN*i +: XLEN];
        end
      end
    end
  end

  assign wb.req_ready = gnt;

  logic        clr_en;
  logic        set_en;
  logic [31:0] busy_nxt;

  assign clr_en = found && (g_addr != 5'd0);

  // A reservation may reuse a register whose write retires this cycle.
  assign reserve_ready = !busy[reserve_addr]
                       | (clr_en && (g_addr == reserve_addr))
                       | (reserve_addr == 5'd0);

  assign set_en = reserve_valid && reserve_ready
               && (reserve_addr != 5'd0);

  // Set is applied after clear so a same-cycle reuse stays busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[g_addr] = 1'b0;
    if (set_en) busy_nxt[reserve_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  logic hz1;
  logic hz2;

`ifdef REGFILE_WB_BYPASS_EN
  assign hz1 = busy[rs1_addr] & ~(found && (g_addr == rs1_addr));
  assign hz2 = busy[rs2_addr] & ~(found && (g_addr == rs2_addr));
`else
  assign hz1 = busy[rs1_addr];
  assign hz2 = busy[rs2_addr];
`endif

  assign stall = ((rs1_addr != 5'd0) & hz1)
               | ((rs2_addr != 5'd0) & hz2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      busy    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy <= busy_nxt;
      if (found) begin
        rr_ptr  <= nxt_ptr;
        wr_en   <= (g_addr != 5'd0);
        wr_addr <= g_addr;
        wr_data <= g_data;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=2).
// Covers reset, fairness, x0 writes, scoreboard, set/clear, async reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reserve_valid = 1'b0;
  logic [4:0]  reserve_addr = '0;
  logic        reserve_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        stall;
  logic [31:0] busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(2), .XLEN(32)) wb ();

  regfile_wb_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb            (wb),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .reserve_ready (reserve_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .stall         (stall),
    .busy          (busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    wb.req_valid = v;
    wb.req_addr  = {a1, a0};
    wb.req_data  = {d1, d0};
  endtask

  task automatic test_reset();
    set_req(2'b11, 5'd5, 32'hA0, 5'd6, 32'hA1);
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wr_en: got %b want 0", wr_en);
    end
    n_cmp++;
    if (busy !== 32'h0) begin
      n_err++;
      $display("FAIL reset_busy: got %h want 0", busy);
    end
    n_cmp++;
    if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_wr_port: got %0d/%h want 0/0", wr_addr, wr_data);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wb.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want 01", wb.req_ready);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_rdy [4];
    logic [4:0]  exp_a   [4];
    logic [31:0] exp_d   [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a   = '{5'd5, 5'd6, 5'd5, 5'd6};
    exp_d   = '{32'hA0, 32'hA1, 32'hA0, 32'hA1};
    set_req(2'b11, 5'd5, 32'hA0, 5'd6, 32'hA1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (wb.req_ready !== exp_rdy[k]) begin
        n_err++;
        $display("FAIL fair_grant%0d: got %b want %b",
                 k, wb.req_ready, exp_rdy[k]);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== exp_a[k] || wr_data !== exp_d[k]) begin
        n_err++;
        $display("FAIL fair_write%0d: got %b/%0d/%h want 1/%0d/%h",
                 k, wr_en, wr_addr, wr_data, exp_a[k], exp_d[k]);
      end
    end
    set_req(2'b00, 5'd5, 32'hA0, 5'd6, 32'hA1);
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd6 || wr_data !== 32'hA1) begin
      n_err++;
      $display("FAIL idle_hold: got %b/%0d/%h want 0/6/a1",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_x0_write();
    set_req(2'b01, 5'd0, 32'hDEADBEEF, 5'd6, 32'hA1);
    #1;
    n_cmp++;
    if (wb.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL x0_ready: got %b want 01", wb.req_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || busy !== 32'h0) begin
      n_err++;
      $display("FAIL x0_no_write: got wr_en=%b busy=%h want 0/0",
               wr_en, busy);
    end
    set_req(2'b11, 5'd5, 32'hA0, 5'd6, 32'hA1);
    #1;
    n_cmp++;
    if (wb.req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL x0_ptr_adv: got %b want 10", wb.req_ready);
    end
    set_req(2'b00, 5'd5, 32'hA0, 5'd6, 32'hA1);
  endtask

  task automatic test_scoreboard();
    reserve_valid = 1'b1;
    reserve_addr  = 5'd7;
    #1;
    n_cmp++;
    if (reserve_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sb_res_rdy: got %b want 1", reserve_ready);
    end
    tick();
    rs1_addr = 5'd7;
    #1;
    n_cmp++;
    if (busy !== 32'h80 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL sb_busy7: got busy=%h stall=%b want 80/1", busy, stall);
    end
    n_cmp++;
    if (reserve_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sb_re_reserve: got %b want 0", reserve_ready);
    end
    tick();
    reserve_valid = 1'b0;
    n_cmp++;
    if (busy !== 32'h80) begin
      n_err++;
      $display("FAIL sb_refused_hold: got %h want 80", busy);
    end
    set_req(2'b10, 5'd5, 32'hA0, 5'd7, 32'h77);
    #1;
    n_cmp++;
    if (wb.req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL sb_grant1: got %b want 10", wb.req_ready);
    end
    n_cmp++;
`ifdef REGFILE_WB_BYPASS_EN
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL sb_stall_grant: got %b want 0", stall);
    end
`else
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL sb_stall_grant: got %b want 1", stall);
    end
`endif
    tick();
    set_req(2'b00, 5'd5, 32'hA0, 5'd7, 32'h77);
    #1;
    n_cmp++;
    if (busy !== 32'h0 || stall !== 1'b0 || wr_en !== 1'b1 ||
        wr_addr !== 5'd7 || wr_data !== 32'h77) begin
      n_err++;
      $display("FAIL sb_release: got busy=%h stall=%b wr=%b/%0d/%h want 0/0/1/7/77",
               busy, stall, wr_en, wr_addr, wr_data);
    end
    rs1_addr = 5'd0;
  endtask

  task automatic test_set_clear();
    reserve_valid = 1'b1;
    reserve_addr  = 5'd9;
    tick();
    reserve_valid = 1'b0;
    n_cmp++;
    if (busy !== 32'h200) begin
      n_err++;
      $display("FAIL sc_busy9: got %h want 200", busy);
    end
    set_req(2'b01, 5'd9, 32'h99, 5'd6, 32'hA1);
    reserve_valid = 1'b1;
    #1;
    n_cmp++;
    if (reserve_ready !== 1'b1 || wb.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL sc_ready: got res=%b req=%b want 1/01",
               reserve_ready, wb.req_ready);
    end
    tick();
    reserve_valid = 1'b0;
    set_req(2'b00, 5'd9, 32'h99, 5'd6, 32'hA1);
    n_cmp++;
    if (busy !== 32'h200 || wr_en !== 1'b1 || wr_addr !== 5'd9) begin
      n_err++;
      $display("FAIL sc_set_wins: got busy=%h wr=%b/%0d want 200/1/9",
               busy, wr_en, wr_addr);
    end
    set_req(2'b10, 5'd5, 32'hA0, 5'd9, 32'h98);
    tick();
    set_req(2'b00, 5'd5, 32'hA0, 5'd9, 32'h98);
    n_cmp++;
    if (busy !== 32'h0) begin
      n_err++;
      $display("FAIL sc_clear: got %h want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    set_req(2'b01, 5'd4, 32'h44, 5'd6, 32'hA1);
    reserve_valid = 1'b1;
    reserve_addr  = 5'd3;
    tick();
    set_req(2'b00, 5'd4, 32'h44, 5'd6, 32'hA1);
    reserve_valid = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd4 || busy !== 32'h8) begin
      n_err++;
      $display("FAIL ar_pre: got wr=%b/%0d busy=%h want 1/4/8",
               wr_en, wr_addr, busy);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (wr_en !== 1'b0 || busy !== 32'h0 || wr_addr !== 5'd0) begin
      n_err++;
      $display("FAIL ar_drop: got wr=%b/%0d busy=%h want 0/0/0",
               wr_en, wr_addr, busy);
    end
    tick();
    reset = 1'b1;
    set_req(2'b11, 5'd5, 32'hA0, 5'd6, 32'hA1);
    #1;
    n_cmp++;
    if (wb.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL ar_ptr_reset: got %b want 01", wb.req_ready);
    end
    set_req(2'b00, 5'd5, 32'hA0, 5'd6, 32'hA1);
  endtask

  initial begin
    #20000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    test_reset();
    test_fairness();
    test_x0_write();
    test_scoreboard();
    test_set_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
